apb_master: RTL
===============

APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 6, APB address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, APB data width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, command FIFO entries; power of two, used only with APB_MASTER_FIFO_EN.
REQ-004 SHALL have port pclk_i  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port preset_n_i  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port cmd_valid_i  in  1  command request.
REQ-007 SHALL have port cmd_ready_o  out  1  command accepted when high with cmd_valid_i at a rising edge.
REQ-008 SHALL have port cmd_write_i  in  1  1 = write, 0 = read.
REQ-009 SHALL have port cmd_addr_i  in  ADDR_WIDTH  target register offset.
REQ-010 SHALL have port cmd_wdata_i  in  DATA_WIDTH  write data; ignored for reads.
REQ-011 SHALL have port rsp_valid_o  out  1  one-cycle completion pulse; no backpressure.
REQ-012 SHALL have port rsp_write_o  out  1  type of the completed transfer.
REQ-013 SHALL have port rsp_rdata_o  out  DATA_WIDTH  read data of the completed read.
REQ-014 SHALL have ports psel_o, penable_o, pwrite_o  out  1 each; paddr_o  out  ADDR_WIDTH; pwdata_o  out  DATA_WIDTH  APB requester outputs.
REQ-015 SHALL have port prdata_i  in  DATA_WIDTH  APB read data from the completer.
REQ-016 SHALL have port busy_o  out  1  high whenever the FSM is outside IDLE, or the FIFO is non-empty.

Function
REQ-017 SHALL implement FSM states IDLE, SETUP and ACCESS; each of SETUP and ACCESS lasts exactly one cycle, because the bus has no pready.
REQ-018 IDLE SHALL drive psel_o=0 and penable_o=0; SETUP SHALL drive psel_o=1 and penable_o=0; ACCESS SHALL drive psel_o=1 and penable_o=1.
REQ-019 paddr_o, pwrite_o and pwdata_o SHALL come from the registered command and SHALL remain stable through SETUP and ACCESS.
REQ-020 pwdata_o SHALL be 0 during reads.
REQ-021 paddr_o, pwrite_o and pwdata_o SHALL hold their last values in IDLE.
REQ-022 Without FIFO: cmd_ready_o = (state==IDLE) || (state==ACCESS); an accepted command is registered, and SETUP is the next cycle.
REQ-023 A command accepted at the edge that ends ACCESS SHALL go directly to SETUP with no IDLE gap.
REQ-024 At the edge ending ACCESS, a read SHALL capture prdata_i into rsp_rdata_o; a write SHALL load 0 into rsp_rdata_o.
REQ-025 rsp_rdata_o SHALL hold its value until the next completion.
REQ-026 rsp_valid_o SHALL pulse high for exactly the one cycle after ACCESS.
REQ-027 rsp_write_o SHALL be valid during that cycle and SHALL hold afterwards.
REQ-028 Commands SHALL be issued strictly in acceptance order; none SHALL be dropped or duplicated.
REQ-029 Without FIFO: the minimum spacing is 2 cycles per transfer; back-to-back throughput is one transfer per 2 cycles.

Reset
REQ-030 Assertion of preset_n_i SHALL immediately force state=IDLE and drive all outputs low, including a transfer in SETUP or ACCESS.
REQ-031 Outputs forced low SHALL include psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, rsp_valid_o, rsp_write_o, rsp_rdata_o, busy_o and cmd_ready_o.
REQ-032 A transfer aborted by reset SHALL produce no rsp_valid_o pulse.
REQ-033 Reset SHALL flush the FIFO, with pointers and count set to 0.
REQ-034 cmd_ready_o SHALL rise in the first cycle after deassertion of preset_n_i.

Configuration
REQ-035 Macro APB_MASTER_FIFO_EN defined: commands SHALL enter a FIFO_DEPTH-entry FIFO, and cmd_ready_o SHALL equal !full.
REQ-036 With APB_MASTER_FIFO_EN, a push while full SHALL be impossible (ready low), even if a pop occurs in the same cycle.
REQ-037 With APB_MASTER_FIFO_EN, the FSM SHALL pop the head when it is in IDLE or ACCESS and the FIFO is non-empty.
REQ-038 With APB_MASTER_FIFO_EN, SETUP SHALL start 2 cycles after acceptance when the FIFO was empty.
REQ-039 With APB_MASTER_FIFO_EN, the count SHALL wrap correctly at FIFO_DEPTH.
REQ-040 Macro undefined: no FIFO SHALL be present, and behaviour SHALL follow REQ-022 to REQ-029.

Verification
REQ-041 Write (no FIFO): accept {write, 0x14, 0x05} at edge N -> cycle N+1 psel=1 penable=0 paddr=0x14 pwdata=0x05 pwrite=1; cycle N+2 penable=1; cycle N+3 rsp_valid=1, rsp_write=1, rsp_rdata=0.
REQ-042 Read: accept {read, 0x08} with prdata_i=0x00000093 during ACCESS -> rsp_rdata_o=0x00000093 with the rsp_valid pulse, held afterwards.
REQ-043 Back-to-back: cmd_valid_i held with writes to 0x04, 0x08, 0x0C -> SETUP/ACCESS pairs on consecutive cycles with no idle cycle; 3 rsp pulses spaced 2 cycles apart.
REQ-044 Reset mid-ACCESS: assert preset_n_i low during ACCESS of a read -> psel_o and penable_o low immediately; no rsp pulse; cmd_ready_o=1 the cycle after release.
REQ-045 FIFO (APB_MASTER_FIFO_EN): push 6 commands on consecutive cycles to 0x04, 0x08, 0x0C, 0x10, 0x14, 0x04 -> cmd_ready_o low while 4 are queued; all 6 issued in order; busy_o low only after the final rsp pulse.

Source files
------------

// File: rtl/apb_master_if.sv
// Command/response handshake and APB requester signals for apb_master.
// The master modport is the apb_master view; slave is the environment view.
interface apb_master_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
);
  logic                  cmd_valid_i;
  logic                  cmd_ready_o;
  logic                  cmd_write_i;
  logic [ADDR_WIDTH-1:0] cmd_addr_i;
  logic [DATA_WIDTH-1:0] cmd_wdata_i;
  logic                  rsp_valid_o;
  logic                  rsp_write_o;
  logic [DATA_WIDTH-1:0] rsp_rdata_o;
  logic                  psel_o;
  logic                  penable_o;
  logic                  pwrite_o;
  logic [ADDR_WIDTH-1:0] paddr_o;
  logic [DATA_WIDTH-1:0] pwdata_o;
  logic [DATA_WIDTH-1:0] prdata_i;
  logic                  busy_o;

  modport master (
    input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, prdata_i,
    output cmd_ready_o, rsp_valid_o, rsp_write_o, rsp_rdata_o,
           psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, busy_o
  );

  modport slave (
    output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, prdata_i,
    input  cmd_ready_o, rsp_valid_o, rsp_write_o, rsp_rdata_o,
           psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, busy_o
  );
endinterface

// File: rtl/apb_master.sv
// APB requester (no pready): IDLE/SETUP/ACCESS FSM fed by a cmd/rsp handshake.
// Defining APB_MASTER_FIFO_EN inserts a FIFO_DEPTH-entry command FIFO.
module apb_master #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input logic          pclk_i,
  input logic          preset_n_i,
  apb_master_if.master bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_e;

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("apb_master: FIFO_DEPTH must be a power of two >= 2");
  end

  state_e                state_q, state_d;
  logic                  psel_q, psel_d, penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  rsp_valid_q, rsp_valid_d, rsp_write_q, rsp_write_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  cmd_ready_q, cmd_ready_d, busy_q, busy_d;
  logic                  queued_d;
  logic                  take_s, src_write_s;
  logic [ADDR_WIDTH-1:0] src_addr_s;
  logic [DATA_WIDTH-1:0] src_wdata_s;

`ifdef APB_MASTER_FIFO_EN
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = 1 + ADDR_WIDTH + DATA_WIDTH;

  logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               push_s, pop_s;

  // FIFO pointer/count next state; cmd_ready_q already reflects !full for this cycle.
  always_comb begin
    push_s   = bus.cmd_valid_i && cmd_ready_q;
    pop_s    = ((state_q == IDLE) || (state_q == ACCESS)) && (count_q != {CNT_W{1'b0}});
    wr_ptr_d = push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
    take_s   = pop_s;
    {src_write_s, src_addr_s, src_wdata_s} = mem_q[rd_ptr_q];
    cmd_ready_d = (count_d != CNT_W'(FIFO_DEPTH));
    queued_d    = (count_d != {CNT_W{1'b0}});
  end

  // Entry storage; count gates every read so contents need no reset.
  always_ff @(posedge pclk_i) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {bus.cmd_write_i, bus.cmd_addr_i, bus.cmd_wdata_i};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge pclk_i or negedge preset_n_i) begin
    if (!preset_n_i) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
`else
  // Direct issue: ready only in IDLE/ACCESS, and held low in the first cycle after reset.
  always_comb begin
    take_s      = bus.cmd_valid_i && cmd_ready_q;
    src_write_s = bus.cmd_write_i;
    src_addr_s  = bus.cmd_addr_i;
    src_wdata_s = bus.cmd_wdata_i;
    cmd_ready_d = (state_d == IDLE) || (state_d == ACCESS);
    queued_d    = 1'b0;
  end
`endif

  // FSM next state and next values of every registered output.
  always_comb begin
    state_d     = state_q;
    rsp_valid_d = 1'b0;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      IDLE: begin
        if (take_s) state_d = SETUP;
        else        state_d = IDLE;
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        rsp_valid_d = 1'b1;
        rsp_write_d = pwrite_q;
        rsp_rdata_d = pwrite_q ? {DATA_WIDTH{1'b0}} : bus.prdata_i;
        if (take_s) state_d = SETUP;
        else        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (take_s) begin
      paddr_d  = src_addr_s;
      pwrite_d = src_write_s;
      pwdata_d = src_write_s ? src_wdata_s : {DATA_WIDTH{1'b0}};
    end else begin
      paddr_d  = paddr_q;
      pwrite_d = pwrite_q;
      pwdata_d = pwdata_q;
    end
    psel_d    = (state_d != IDLE);
    penable_d = (state_d == ACCESS);
    busy_d    = (state_d != IDLE) || queued_d;
  end

  // FSM state and registered outputs; reset aborts any transfer without a response.
  always_ff @(posedge pclk_i or negedge preset_n_i) begin
    if (!preset_n_i) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= {ADDR_WIDTH{1'b0}};
      pwdata_q    <= {DATA_WIDTH{1'b0}};
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= {DATA_WIDTH{1'b0}};
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.psel_o      = psel_q;
  assign bus.penable_o   = penable_q;
  assign bus.pwrite_o    = pwrite_q;
  assign bus.paddr_o     = paddr_q;
  assign bus.pwdata_o    = pwdata_q;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_write_o = rsp_write_q;
  assign bus.rsp_rdata_o = rsp_rdata_q;
  assign bus.cmd_ready_o = cmd_ready_q;
  assign bus.busy_o      = busy_q;
endmodule
